// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, function
// codes, datapath mux selects, ALU operations and the FSM state set.
package mips_mc_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_INC   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Next-PC select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Controller states; encodings 12..15 are unreachable
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPE   = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    // Width-independent control outputs (irwrite is handled separately)
    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic       memtoreg;
        logic       iord;
        logic       pcen;
        logic       regwrite;
        logic       regdst;
        logic [1:0] pcsrc;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic       illegal;
    } ctrl_t;

    // Beat counter width: a single-beat fetch still keeps a 1-bit counter
    function automatic int beat_bits(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // True for every opcode the controller knows how to execute
    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: return 1'b1;
            default:                                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_aludec.sv
// Function-field decoder for R-type instructions: maps funct to an ALU
// operation and reports whether the funct is one the core implements.
module mips_mc_aludec
    import mips_mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_valid
);

    // Translate funct to the ALU operation; unknown codes select AND and flag invalid
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        alucontrol  = ALU_AND;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  alucontrol = ALU_ADD;
            FN_SUB:  alucontrol = ALU_SUB;
            FN_AND:  alucontrol = ALU_AND;
            FN_OR:   alucontrol = ALU_OR;
            FN_SLT:  alucontrol = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit. Fetches a 32-bit instruction over
// 32/MEM_W memory beats, then sequences the datapath through decode,
// execute, memory and writeback. All outputs are decoded combinationally
// from the current state, the fetch beat and the instruction fields.
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter  int MEM_W = 8,
    localparam int BEATS = 32 / MEM_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             memread,
    output logic             memwrite,
    output logic             alusrca,
    output logic             memtoreg,
    output logic             iord,
    output logic             pcen,
    output logic             regwrite,
    output logic             regdst,
    output logic [1:0]       pcsrc,
    output logic [1:0]       alusrcb,
    output logic [2:0]       alucontrol,
    output logic [BEATS-1:0] irwrite,
    output logic             illegal
);

    localparam int                BEAT_W    = beat_bits(BEATS);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [BEATS-1:0]  LANE0     = BEATS'(1);

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    ctrl_t             ctrl;
    logic [2:0]        rtype_alu;
    logic              funct_valid;

    mips_mc_aludec u_aludec (
        .funct       (funct),
        .alucontrol  (rtype_alu),
        .funct_valid (funct_valid)
    );

    // State and fetch-beat registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values regardless of block ordering.
        if (reset) begin
            state_q <= S_FETCH;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next state and next beat; the beat only advances inside FETCH
    always_comb begin
        state_d = state_q;
        beat_d  = '0;
        case (state_q)
            S_FETCH: begin
                beat_d = beat_q;
                if (mem_ready) begin
                    if (beat_q == BEAT_LAST) begin
                        beat_d  = '0;
                        state_d = S_DECODE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_RTYPE:       state_d = S_RTYPE;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDIEX;
                    OP_J:           state_d = S_JUMP;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPE:   state_d = funct_valid ? S_RTYPEWB : S_FETCH;
            S_RTYPEWB: state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Control outputs decoded from state, beat and instruction fields
    always_comb begin
        ctrl    = '0;
        irwrite = '0;
        // NOTE: outputs are gated by reset itself, not by the registered state,
        // so an access in flight is dropped in the very cycle reset rises.
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ctrl.memread    = 1'b1;
                    ctrl.alusrcb    = SRCB_INC;
                    ctrl.alucontrol = ALU_ADD;
                    ctrl.pcsrc      = PC_ALU;
                    if (mem_ready) begin
                        irwrite   = LANE0 << beat_q;
                        ctrl.pcen = 1'b1;
                    end
                end
                S_DECODE: begin
                    ctrl.alusrcb    = SRCB_IMMSH;
                    ctrl.alucontrol = ALU_ADD;
                    ctrl.illegal    = ~op_legal(op);
                end
                S_MEMADR, S_ADDIEX: begin
                    ctrl.alusrca    = 1'b1;
                    ctrl.alusrcb    = SRCB_IMM;
                    ctrl.alucontrol = ALU_ADD;
                end
                S_MEMRD: begin
                    ctrl.memread = 1'b1;
                    ctrl.iord    = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.regwrite = 1'b1;
                    ctrl.memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    ctrl.memwrite = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                S_RTYPE: begin
                    ctrl.alusrca    = 1'b1;
                    ctrl.alusrcb    = SRCB_REGB;
                    ctrl.alucontrol = rtype_alu;
                    ctrl.illegal    = ~funct_valid;
                end
                S_RTYPEWB: begin
                    ctrl.regwrite = 1'b1;
                    ctrl.regdst   = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alusrca    = 1'b1;
                    ctrl.alusrcb    = SRCB_REGB;
                    ctrl.alucontrol = ALU_SUB;
                    ctrl.pcsrc      = PC_ALUOUT;
                    ctrl.pcen       = (op == OP_BNE) ? ~zero : zero;
                end
                S_ADDIWB: begin
                    ctrl.regwrite = 1'b1;
                end
                S_JUMP: begin
                    ctrl.pcsrc = PC_JUMP;
                    ctrl.pcen  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign memread    = ctrl.memread;
    assign memwrite   = ctrl.memwrite;
    assign alusrca    = ctrl.alusrca;
    assign memtoreg   = ctrl.memtoreg;
    assign iord       = ctrl.iord;
    assign pcen       = ctrl.pcen;
    assign regwrite   = ctrl.regwrite;
    assign regdst     = ctrl.regdst;
    assign pcsrc      = ctrl.pcsrc;
    assign alusrcb    = ctrl.alusrcb;
    assign alucontrol = ctrl.alucontrol;
    assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: three instances (MEM_W 8/16/32) share the
// inputs; a selector picks which one is compared. Directed table rows
// cover the corner sequences, then randomized instruction streams are
// compared against a per-instruction step-list model.
module tb_mips_mc_controller;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
    localparam logic [5:0] JMP = 6'b000010, BADOP = 6'b111111;
    localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010, FAND = 6'b100100;
    localparam logic [5:0] FOR = 6'b100101, FSLT = 6'b101010, BADFN = 6'b000111;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic       memtoreg;
        logic       iord;
        logic       pcen;
        logic       regwrite;
        logic       regdst;
        logic [1:0] pcsrc;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic [3:0] irwrite;
        logic       illegal;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] op, funct;
    int         sel;
    outs_t      got;
    int         n_pass = 0;
    int         n_total = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = 8 << g;
        localparam int B = 32 / W;
        logic memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst, illegal;
        logic [1:0] pcsrc, alusrcb;
        logic [2:0] alucontrol;
        logic [B-1:0] irwrite;
        outs_t o;
        mips_mc_controller #(.MEM_W(W)) dut (
            .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
            .mem_ready(mem_ready), .memread(memread), .memwrite(memwrite),
            .alusrca(alusrca), .memtoreg(memtoreg), .iord(iord), .pcen(pcen),
            .regwrite(regwrite), .regdst(regdst), .pcsrc(pcsrc), .alusrcb(alusrcb),
            .alucontrol(alucontrol), .irwrite(irwrite), .illegal(illegal)
        );
        assign o = '{memread: memread, memwrite: memwrite, alusrca: alusrca,
                     memtoreg: memtoreg, iord: iord, pcen: pcen, regwrite: regwrite,
                     regdst: regdst, pcsrc: pcsrc, alusrcb: alusrcb,
                     alucontrol: alucontrol, irwrite: 4'(irwrite), illegal: illegal};
    end

    always_comb begin
        case (sel)
            0:       got = g_dut[0].o;
            1:       got = g_dut[1].o;
            default: got = g_dut[2].o;
        endcase
    end

    task automatic check(input string name, input outs_t act, input outs_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected-output constructors, one per control step
    function automatic outs_t o_fetch(input logic [3:0] lane, input logic rdy);
        outs_t o = '0;
        o.memread = 1; o.alusrcb = 2'b01; o.alucontrol = 3'b010;
        if (rdy) begin o.irwrite = lane; o.pcen = 1; end
        return o;
    endfunction
    function automatic outs_t o_decode(input logic ill);
        outs_t o = '0;
        o.alusrcb = 2'b11; o.alucontrol = 3'b010; o.illegal = ill;
        return o;
    endfunction
    function automatic outs_t o_memadr();
        outs_t o = '0;
        o.alusrca = 1; o.alusrcb = 2'b10; o.alucontrol = 3'b010;
        return o;
    endfunction
    function automatic outs_t o_memrd();
        outs_t o = '0; o.memread = 1; o.iord = 1; return o;
    endfunction
    function automatic outs_t o_memwb();
        outs_t o = '0; o.regwrite = 1; o.memtoreg = 1; return o;
    endfunction
    function automatic outs_t o_memwr();
        outs_t o = '0; o.memwrite = 1; o.iord = 1; return o;
    endfunction
    function automatic outs_t o_rtype(input logic [2:0] ac, input logic ill);
        outs_t o = '0; o.alusrca = 1; o.alucontrol = ac; o.illegal = ill; return o;
    endfunction
    function automatic outs_t o_rtypewb();
        outs_t o = '0; o.regwrite = 1; o.regdst = 1; return o;
    endfunction
    function automatic outs_t o_branch(input logic pc);
        outs_t o = '0;
        o.alusrca = 1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = pc;
        return o;
    endfunction
    function automatic outs_t o_addiwb();
        outs_t o = '0; o.regwrite = 1; return o;
    endfunction
    function automatic outs_t o_jump();
        outs_t o = '0; o.pcsrc = 2'b10; o.pcen = 1; return o;
    endfunction

    // funct -> {valid, alu op}
    function automatic logic [3:0] fn_map(input logic [5:0] fn);
        case (fn)
            FADD:    return 4'b1_010;
            FSUB:    return 4'b1_110;
            FAND:    return 4'b1_000;
            FOR:     return 4'b1_001;
            FSLT:    return 4'b1_111;
            default: return 4'b0_000;
        endcase
    endfunction

    // Directed vectors
    typedef struct {
        int         s;
        logic       r, rdy;
        logic [5:0] op, fn;
        logic       z;
        outs_t      exp;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input int s, input logic r, input logic rdy, input logic [5:0] o,
                       input logic [5:0] fn, input logic z, input outs_t e);
        vecs.push_back('{s, r, rdy, o, fn, z, e});
    endtask

    // Randomized model: each instruction expands into a list of steps
    typedef struct {
        int         kind;   // 0 = one cycle, 1 = fetch beat, 2 = waits for mem_ready
        outs_t      o;
        logic [3:0] lane;
    } step_t;
    step_t steps[$];

    task automatic push(input int kind, input outs_t o, input logic [3:0] lane);
        steps.push_back('{kind, o, lane});
    endtask

    task automatic new_instr(input int beats);
        int         pick = $urandom_range(0, 9);
        logic [3:0] fm;
        logic [5:0] fns[5] = '{FADD, FSUB, FAND, FOR, FSLT};
        case (pick)
            0: op = LW;   1: op = SW;   2, 3: op = RT;  4: op = BEQ;
            5: op = BNE;  6: op = ADDI; 7: op = JMP;
            default: op = 6'($urandom);
        endcase
        funct = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
        zero  = 1'($urandom);
        for (int i = 0; i < beats; i++) push(1, '0, 4'(1 << i));
        case (op)
            LW:  begin push(0, o_decode(0), 0); push(0, o_memadr(), 0);
                       push(2, o_memrd(), 0); push(0, o_memwb(), 0); end
            SW:  begin push(0, o_decode(0), 0); push(0, o_memadr(), 0);
                       push(2, o_memwr(), 0); end
            RT:  begin
                fm = fn_map(funct);
                push(0, o_decode(0), 0);
                push(0, o_rtype(fm[2:0], !fm[3]), 0);
                if (fm[3]) push(0, o_rtypewb(), 0);
            end
            BEQ: begin push(0, o_decode(0), 0); push(0, o_branch(zero), 0); end
            BNE: begin push(0, o_decode(0), 0); push(0, o_branch(!zero), 0); end
            ADDI: begin push(0, o_decode(0), 0); push(0, o_memadr(), 0);
                        push(0, o_addiwb(), 0); end
            JMP: begin push(0, o_decode(0), 0); push(0, o_jump(), 0); end
            default: push(0, o_decode(1), 0);
        endcase
    endtask

    task automatic run_random(input int s, input int ncyc);
        outs_t exp;
        sel = s;
        reset = 1; mem_ready = 1;
        #1 check($sformatf("rand_w%0d_reset", 8 << s), got, '0);
        @(posedge clk); #1;
        reset = 0;
        steps.delete();
        for (int c = 0; c < ncyc; c++) begin
            if (steps.size() == 0) new_instr(32 / (8 << s));
            mem_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp = (steps[0].kind == 1) ? o_fetch(steps[0].lane, mem_ready) : steps[0].o;
            check($sformatf("rand_w%0d_c%0d_op%b", 8 << s, c, op), got, exp);
            if (steps[0].kind == 0 || mem_ready) void'(steps.pop_front());
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1; mem_ready = 0; op = '0; funct = '0; zero = 0; sel = 0;

        // MEM_W=8: reset held 3 cycles, then 4 fetch beats and DECODE
        for (int i = 0; i < 3; i++) add(0, 1, 1, RT, FADD, 0, '0);
        add(0, 0, 1, RT, FADD, 0, o_fetch(4'b0001, 1));
        add(0, 0, 1, RT, FADD, 0, o_fetch(4'b0010, 1));
        add(0, 0, 1, RT, FADD, 0, o_fetch(4'b0100, 1));
        add(0, 0, 1, RT, FADD, 0, o_fetch(4'b1000, 1));
        add(0, 0, 1, RT, FADD, 0, o_decode(0));
        // MEM_W=32: R-type add, four cycles
        add(2, 1, 1, RT, FADD, 0, '0);
        add(2, 0, 1, RT, FADD, 0, o_fetch(4'b0001, 1));
        add(2, 0, 1, RT, FADD, 0, o_decode(0));
        add(2, 0, 1, RT, FADD, 0, o_rtype(3'b010, 0));
        add(2, 0, 1, RT, FADD, 0, o_rtypewb());
        add(2, 0, 1, RT, FADD, 0, o_fetch(4'b0001, 1));
        // MEM_W=16: lw with stalls in both fetch beats and in MEMRD
        add(1, 1, 1, LW, 0, 0, '0);
        add(1, 0, 0, LW, 0, 0, o_fetch(0, 0));
        add(1, 0, 0, LW, 0, 0, o_fetch(0, 0));
        add(1, 0, 1, LW, 0, 0, o_fetch(4'b0001, 1));
        add(1, 0, 0, LW, 0, 0, o_fetch(0, 0));
        add(1, 0, 0, LW, 0, 0, o_fetch(0, 0));
        add(1, 0, 1, LW, 0, 0, o_fetch(4'b0010, 1));
        add(1, 0, 1, LW, 0, 0, o_decode(0));
        add(1, 0, 1, LW, 0, 0, o_memadr());
        for (int i = 0; i < 3; i++) add(1, 0, 0, LW, 0, 0, o_memrd());
        add(1, 0, 1, LW, 0, 0, o_memrd());
        add(1, 0, 1, LW, 0, 0, o_memwb());
        add(1, 0, 1, LW, 0, 0, o_fetch(4'b0001, 1));
        // MEM_W=32: beq taken, beq not taken, bne taken
        add(2, 1, 1, BEQ, 0, 1, '0);
        add(2, 0, 1, BEQ, 0, 1, o_fetch(4'b0001, 1));
        add(2, 0, 1, BEQ, 0, 1, o_decode(0));
        add(2, 0, 1, BEQ, 0, 1, o_branch(1));
        add(2, 0, 1, BEQ, 0, 0, o_fetch(4'b0001, 1));
        add(2, 0, 1, BEQ, 0, 0, o_decode(0));
        add(2, 0, 1, BEQ, 0, 0, o_branch(0));
        add(2, 0, 1, BNE, 0, 0, o_fetch(4'b0001, 1));
        add(2, 0, 1, BNE, 0, 0, o_decode(0));
        add(2, 0, 1, BNE, 0, 0, o_branch(1));
        // MEM_W=32: illegal op, illegal funct, then addi and j
        add(2, 1, 1, BADOP, 0, 0, '0);
        add(2, 0, 1, BADOP, 0, 0, o_fetch(4'b0001, 1));
        add(2, 0, 1, BADOP, 0, 0, o_decode(1));
        add(2, 0, 1, RT, BADFN, 0, o_fetch(4'b0001, 1));
        add(2, 0, 1, RT, BADFN, 0, o_decode(0));
        add(2, 0, 1, RT, BADFN, 0, o_rtype(3'b000, 1));
        add(2, 0, 1, ADDI, 0, 0, o_fetch(4'b0001, 1));
        add(2, 0, 1, ADDI, 0, 0, o_decode(0));
        add(2, 0, 1, ADDI, 0, 0, o_memadr());
        add(2, 0, 1, ADDI, 0, 0, o_addiwb());
        add(2, 0, 1, JMP, 0, 0, o_fetch(4'b0001, 1));
        add(2, 0, 1, JMP, 0, 0, o_decode(0));
        add(2, 0, 1, JMP, 0, 0, o_jump());
        add(2, 0, 1, JMP, 0, 0, o_fetch(4'b0001, 1));
        // MEM_W=8: sw interrupted by reset while stalled in MEMWR
        add(0, 1, 1, SW, 0, 0, '0);
        add(0, 0, 1, SW, 0, 0, o_fetch(4'b0001, 1));
        add(0, 0, 1, SW, 0, 0, o_fetch(4'b0010, 1));
        add(0, 0, 1, SW, 0, 0, o_fetch(4'b0100, 1));
        add(0, 0, 1, SW, 0, 0, o_fetch(4'b1000, 1));
        add(0, 0, 1, SW, 0, 0, o_decode(0));
        add(0, 0, 1, SW, 0, 0, o_memadr());
        add(0, 0, 0, SW, 0, 0, o_memwr());
        add(0, 1, 0, SW, 0, 0, '0);
        add(0, 0, 1, SW, 0, 0, o_fetch(4'b0001, 1));

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            sel = vecs[i].s; reset = vecs[i].r; mem_ready = vecs[i].rdy;
            op = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z;
            #1 check($sformatf("vec%0d_w%0d", i, 8 << vecs[i].s), got, vecs[i].exp);
            @(posedge clk); #1;
        end

        for (int s = 0; s < 3; s++) run_random(s, 400);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
